// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that turns an external 1W/1R registered-read RAM into a FIFO.
// Owns pointers, occupancy, status flags and sticky error flags; no data path.
module fifo_ctrl #(
  parameter int ADDR_W = 6,
  parameter int AF_THR = 2**ADDR_W-1,
  parameter int AE_THR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_req,
  input  logic              r_req,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic              r_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_THR);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_THR);
  localparam logic [ADDR_W:0] LV_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] P_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              r_valid_q;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              w_acc, r_acc;

  // Flags decode the registered level only, so requests cannot glitch them.
  assign full         = (level_q == DEPTH_L);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);

  assign w_acc = w_req & ~full & ~clr;
  assign r_acc = r_req & ~empty & ~clr;

  assign ram_w_en   = w_acc;
  assign ram_r_en   = r_acc;
  assign ram_w_addr = wptr_q;
  assign ram_r_addr = rptr_q;
  assign r_valid    = r_valid_q;
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (w_acc) wptr_d = wptr_q + P_ONE;
      if (r_acc) rptr_d = rptr_q + P_ONE;
      case ({w_acc, r_acc})
        2'b10:   level_d = level_q + LV_ONE;
        2'b01:   level_d = level_q - LV_ONE;
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q | (w_req & full);
      unf_d = unf_q | (r_req & empty);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      r_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      r_valid_q <= r_acc;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (depth 4): directed scenarios plus random traffic
// against a queue-based FIFO model and a behavioural registered-read RAM.
module tb_fifo_ctrl;

  logic       clk, rst, clr, w_req, r_req;
  logic       ram_w_en, ram_r_en, r_valid;
  logic [1:0] ram_w_addr, ram_r_addr;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] level;
  logic       overflow, underflow;

  fifo_ctrl #(.ADDR_W(2), .AF_THR(3), .AE_THR(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .w_req(w_req), .r_req(r_req),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr),
    .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external RAM with registered read
  logic [7:0] wdata, rdata;
  logic [7:0] mem [4];
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= wdata;
    if (ram_r_en) rdata <= mem[ram_r_addr];
  end

  int total = 0;
  int passed = 0;

  // reference model
  logic [7:0] q[$];
  int         m_w, m_r;
  bit         m_ov, m_un, m_rv, e_wa, e_ra;
  logic [7:0] exp_rd;

  task automatic model_reset();
    q.delete();
    m_w = 0; m_r = 0;
    m_ov = 0; m_un = 0; m_rv = 0;
  endtask

  task automatic set_in(bit w, bit r, bit c);
    w_req = w; r_req = r; clr = c;
    wdata = 8'($urandom);
    #1;
    e_wa = w && q.size() != 4 && !c;
    e_ra = r && q.size() != 0 && !c;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (clr) begin
      model_reset();
    end else begin
      if (w_req && q.size() == 4) m_ov = 1;
      if (r_req && q.size() == 0) m_un = 1;
      if (e_wa) begin q.push_back(wdata); m_w = (m_w + 1) % 4; end
      if (e_ra) begin exp_rd = q.pop_front(); m_r = (m_r + 1) % 4; end
      m_rv = e_ra;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; clr = 0; w_req = 0; r_req = 0; wdata = 0;
    model_reset();
    #3;
    total++;
    if ({empty, full, level, r_valid, almost_empty, almost_full,
         ram_w_en, ram_r_en, overflow, underflow} !== {1'b1, 1'b0, 3'd0,
         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset: empty=%b full=%b level=%0d rv=%b ae=%b af=%b",
               empty, full, level, r_valid, almost_empty, almost_full);
    else passed++;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0);
      total++;
      if (ram_w_en !== 1'b1 || ram_w_addr !== 2'(i))
        $display("FAIL fill_wr%0d: en=%b addr=%0d want en=1 addr=%0d",
                 i, ram_w_en, ram_w_addr, i);
      else passed++;
      tick();
      total++;
      if (level !== 3'(i + 1) || almost_full !== (i + 1 >= 3) || full !== (i == 3))
        $display("FAIL fill_lvl%0d: level=%0d af=%b full=%b want %0d",
                 i, level, almost_full, full, i + 1);
      else passed++;
    end
    set_in(1, 0, 0);
    total++;
    if (ram_w_en !== 1'b0)
      $display("FAIL fill_reject: ram_w_en=%b want 0", ram_w_en);
    else passed++;
    tick();
    total++;
    if (overflow !== 1'b1 || level !== 3'd4)
      $display("FAIL overflow: ovf=%b level=%0d want 1/4", overflow, level);
    else passed++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0);
      total++;
      if (ram_r_en !== 1'b1 || ram_r_addr !== 2'(i))
        $display("FAIL drain_rd%0d: en=%b addr=%0d want en=1 addr=%0d",
                 i, ram_r_en, ram_r_addr, i);
      else passed++;
      tick();
      total++;
      if (r_valid !== 1'b1 || rdata !== exp_rd || empty !== (i == 3))
        $display("FAIL drain_data%0d: rv=%b data=%h want %h empty=%b",
                 i, r_valid, rdata, exp_rd, empty);
      else passed++;
    end
    set_in(0, 1, 0);
    total++;
    if (ram_r_en !== 1'b0)
      $display("FAIL drain_reject: ram_r_en=%b want 0", ram_r_en);
    else passed++;
    tick();
    total++;
    if (underflow !== 1'b1 || r_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL underflow: unf=%b rv=%b level=%0d", underflow, r_valid, level);
    else passed++;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin set_in(1, 0, 0); tick(); end
    set_in(1, 0, 1);
    total++;
    if (ram_w_en !== 1'b0 || ram_r_en !== 1'b0 || overflow !== 1'b1)
      $display("FAIL clr_gate: wen=%b ren=%b ovf=%b", ram_w_en, ram_r_en, overflow);
    else passed++;
    tick();
    set_in(0, 0, 0);
    total++;
    if (level !== 3'd0 || ram_w_addr !== 2'd0 || ram_r_addr !== 2'd0 ||
        overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1)
      $display("FAIL clr_state: level=%0d wa=%0d ra=%0d ovf=%b unf=%b",
               level, ram_w_addr, ram_r_addr, overflow, underflow);
    else passed++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin set_in(1, 0, 0); tick(); end
    for (int i = 0; i < 3; i++) begin set_in(0, 1, 0); tick(); end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0);
      total++;
      if (ram_w_addr !== 2'((3 + i) % 4))
        $display("FAIL wrap_wa%0d: addr=%0d want %0d", i, ram_w_addr, (3 + i) % 4);
      else passed++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0);
      total++;
      if (ram_r_addr !== 2'((3 + i) % 4))
        $display("FAIL wrap_ra%0d: addr=%0d want %0d", i, ram_r_addr, (3 + i) % 4);
      else passed++;
      tick();
      total++;
      if (r_valid !== 1'b1 || rdata !== exp_rd)
        $display("FAIL wrap_data%0d: rv=%b data=%h want %h", i, r_valid, rdata, exp_rd);
      else passed++;
    end
  endtask

  task automatic test_simul();
    int w0, r0;
    for (int i = 0; i < 2; i++) begin set_in(1, 0, 0); tick(); end
    w0 = m_w; r0 = m_r;
    for (int i = 0; i < 5; i++) begin set_in(1, 1, 0); tick(); end
    total++;
    if (level !== 3'd2 || ram_w_addr !== 2'((w0 + 5) % 4) ||
        ram_r_addr !== 2'((r0 + 5) % 4))
      $display("FAIL simul_mid: level=%0d wa=%0d ra=%0d", level, ram_w_addr, ram_r_addr);
    else passed++;
    for (int i = 0; i < 2; i++) begin set_in(1, 0, 0); tick(); end
    set_in(1, 1, 0);
    total++;
    if (ram_w_en !== 1'b0 || ram_r_en !== 1'b1)
      $display("FAIL simul_full: wen=%b ren=%b want 0/1", ram_w_en, ram_r_en);
    else passed++;
    tick();
    total++;
    if (level !== 3'd3)
      $display("FAIL simul_full_lvl: level=%0d want 3", level);
    else passed++;
    for (int i = 0; i < 3; i++) begin set_in(0, 1, 0); tick(); end
    set_in(1, 1, 0);
    total++;
    if (ram_w_en !== 1'b1 || ram_r_en !== 1'b0)
      $display("FAIL simul_empty: wen=%b ren=%b want 1/0", ram_w_en, ram_r_en);
    else passed++;
    tick();
    total++;
    if (level !== 3'd1)
      $display("FAIL simul_empty_lvl: level=%0d want 1", level);
    else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 39) == 0);
      total++;
      if (ram_w_en !== e_wa || ram_r_en !== e_ra ||
          ram_w_addr !== 2'(m_w) || ram_r_addr !== 2'(m_r) ||
          level !== 3'(q.size()) || full !== (q.size() == 4) ||
          empty !== (q.size() == 0) || almost_full !== (q.size() >= 3) ||
          almost_empty !== (q.size() <= 1) || overflow !== m_ov ||
          underflow !== m_un || r_valid !== m_rv ||
          (m_rv && rdata !== exp_rd)) begin
        if (errs < 5)
          $display("FAIL rand%0d: lvl=%0d/%0d wen=%b/%b ren=%b/%b rv=%b/%b data=%h/%h",
                   n, level, q.size(), ram_w_en, e_wa, ram_r_en, e_ra,
                   r_valid, m_rv, rdata, exp_rd);
        errs++;
      end else passed++;
      tick();
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 2; i++) begin set_in(1, 0, 0); tick(); end
    set_in(0, 1, 0);
    total++;
    if (ram_r_en !== 1'b1)
      $display("FAIL rst_mid_ren: ram_r_en=%b want 1", ram_r_en);
    else passed++;
    rst = 1;
    #1;
    total++;
    if (level !== 3'd0 || empty !== 1'b1)
      $display("FAIL rst_async: level=%0d empty=%b want 0/1", level, empty);
    else passed++;
    tick();
    total++;
    if (r_valid !== 1'b0 || level !== 3'd0 || ram_r_addr !== 2'd0)
      $display("FAIL rst_mid: rv=%b level=%0d ra=%0d", r_valid, level, ram_r_addr);
    else passed++;
    rst = 0;
    set_in(0, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_clear();
    test_wrap();
    test_simul();
    test_random();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
